// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel filter stages: window pixel indices,
// gradient intermediate width and the abs/shift/saturate helper.
package sobel_pkg;

    localparam int unsigned P00 = 0;
    localparam int unsigned P01 = 1;
    localparam int unsigned P02 = 2;
    localparam int unsigned P10 = 3;
    localparam int unsigned P11 = 4;
    localparam int unsigned P12 = 5;
    localparam int unsigned P20 = 6;
    localparam int unsigned P21 = 7;
    localparam int unsigned P22 = 8;

    // Signed width that holds +/-4*(2^w-1) without overflow.
    function automatic int unsigned grad_width(input int unsigned w);
        return w + 3;
    endfunction

    // |g| >> sh, clamped to w bits; caller truncates the result to w bits.
    function automatic logic [31:0] abs_sat_shift(input logic signed [31:0] g,
                                                  input int unsigned      w,
                                                  input int unsigned      sh);
        logic [31:0] a;
        logic [31:0] s;
        logic [31:0] mx;
        a  = (g < 0) ? 32'(-g) : 32'(g);
        s  = a >> sh;
        mx = (32'd1 << w) - 32'd1;
        return (s > mx) ? mx : s;
    endfunction

endpackage

// File: rtl/sobel_pipe_reg.sv
// One valid/ready register slice; accepts whenever empty or draining, so a
// chain of these gives full throughput with backpressure.
module sobel_pipe_reg #(
    parameter int unsigned DW_P = 8
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    input  logic [DW_P-1:0] data_i,
    output logic            ready_o_c,
    output logic            valid_o,
    output logic [DW_P-1:0] data_o,
    input  logic            ready_i
);

    logic            r_valid;
    logic [DW_P-1:0] r_data;
    logic            w_en;

    assign w_en      = ~r_valid | ready_i;
    assign ready_o_c = w_en;
    assign valid_o   = r_valid;
    assign data_o    = r_data;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_en) begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_data <= data_i;
            end
        end
    end

endmodule

// File: rtl/sobel_gradient.sv
// Two-stage Sobel gradient: S1 registers signed gx/gy, S2 registers the
// scaled, saturated magnitudes of each.
module sobel_gradient
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH_P = 8,
    parameter int unsigned SHIFT_P = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [9*WIDTH_P-1:0] window_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH_P-1:0]   gx_o,
    output logic [WIDTH_P-1:0]   gy_o
);

    localparam int unsigned GW  = grad_width(WIDTH_P);
    localparam int unsigned S1W = 2 * GW;
    localparam int unsigned S2W = 2 * WIDTH_P;

    function automatic logic [GW-1:0] pix(input logic [9*WIDTH_P-1:0] win,
                                          input int unsigned         idx);
        return GW'(win[idx*WIDTH_P +: WIDTH_P]);
    endfunction

    logic signed [GW-1:0]      w_gx;
    logic signed [GW-1:0]      w_gy;
    logic                      w_s1_valid;
    logic                      w_s1_ready;
    logic [S1W-1:0]            w_s1_data;
    logic signed [GW-1:0]      w_s1_gx;
    logic signed [GW-1:0]      w_s1_gy;
    logic [WIDTH_P-1:0]        w_s2_gx;
    logic [WIDTH_P-1:0]        w_s2_gy;
    logic [S2W-1:0]            w_s2_data;

    // Column/row weighted sums stay non-negative; only the difference is signed.
    always_comb begin
        w_gx = $signed(pix(window_i, P02) + (pix(window_i, P12) << 1) + pix(window_i, P22))
             - $signed(pix(window_i, P00) + (pix(window_i, P10) << 1) + pix(window_i, P20));
        w_gy = $signed(pix(window_i, P20) + (pix(window_i, P21) << 1) + pix(window_i, P22))
             - $signed(pix(window_i, P00) + (pix(window_i, P01) << 1) + pix(window_i, P02));
    end

    sobel_pipe_reg #(.DW_P(S1W)) u_s1 (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .valid_i   (valid_i),
        .data_i    ({w_gx, w_gy}),
        .ready_o_c (ready_o),
        .valid_o   (w_s1_valid),
        .data_o    (w_s1_data),
        .ready_i   (w_s1_ready)
    );

    always_comb begin
        w_s1_gx = $signed(w_s1_data[S1W-1 -: GW]);
        w_s1_gy = $signed(w_s1_data[GW-1:0]);
        w_s2_gx = WIDTH_P'(abs_sat_shift(32'(w_s1_gx), WIDTH_P, SHIFT_P));
        w_s2_gy = WIDTH_P'(abs_sat_shift(32'(w_s1_gy), WIDTH_P, SHIFT_P));
    end

    sobel_pipe_reg #(.DW_P(S2W)) u_s2 (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .valid_i   (w_s1_valid),
        .data_i    ({w_s2_gx, w_s2_gy}),
        .ready_o_c (w_s1_ready),
        .valid_o   (valid_o),
        .data_o    (w_s2_data),
        .ready_i   (ready_i)
    );

    assign gx_o = w_s2_data[S2W-1 -: WIDTH_P];
    assign gy_o = w_s2_data[WIDTH_P-1:0];

endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient: table vectors, backpressure, random stream with
// a scoreboard, reset mid-flight, and a SHIFT_P=0 instance for saturation.
module tb_sobel_gradient;

    typedef struct {
        logic [71:0] win;
        int          gx;
        int          gy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [71:0] window_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic [7:0]  gx_o;
    logic [7:0]  gy_o;

    logic        v0_i = 1'b0;
    logic        rdy0 = 1'b1;
    logic [71:0] win0 = '0;
    logic        r0_o;
    logic        v0_o;
    logic [7:0]  gx0;
    logic [7:0]  gy0;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pop  = 0;
    int q_gx[$];
    int q_gy[$];

    always #5 clk = ~clk;

    sobel_gradient #(.WIDTH_P(8), .SHIFT_P(2)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
        .window_i(window_i), .valid_o(valid_o), .ready_i(ready_i),
        .gx_o(gx_o), .gy_o(gy_o)
    );

    sobel_gradient #(.WIDTH_P(8), .SHIFT_P(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(v0_i), .ready_o(r0_o),
        .window_i(win0), .valid_o(v0_o), .ready_i(rdy0),
        .gx_o(gx0), .gy_o(gy0)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [71:0] mkw(input logic [7:0] a00, a01, a02,
                                        a10, a11, a12, a20, a21, a22);
        return {a22, a21, a20, a12, a11, a10, a02, a01, a00};
    endfunction

    // Independent reference: integer Sobel, abs, shift, clamp.
    task automatic model(input logic [71:0] w, input int sh, output int egx, output int egy);
        int p[9];
        int gx;
        int gy;
        for (int i = 0; i < 9; i++) p[i] = int'(w[i*8 +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        gx = gx >> sh;
        gy = gy >> sh;
        egx = (gx > 255) ? 255 : gx;
        egy = (gy > 255) ? 255 : gy;
    endtask

    // One cycle: drive at negedge, resolve both handshakes before the next posedge.
    task automatic tick(input logic vin, input logic [71:0] win, input int egx, input int egy,
                        input logic rin, output logic acc, output logic outf);
        @(negedge clk);
        valid_i  = vin;
        window_i = win;
        ready_i  = rin;
        #1;
        acc  = valid_i && ready_o;
        outf = valid_o;
        if (acc) begin
            q_gx.push_back(egx);
            q_gy.push_back(egy);
        end
        if (valid_o && ready_i) begin
            n_pop++;
            if (q_gx.size() == 0) chk("stream_extra_beat", 1, 0);
            else begin
                chk("stream_gx", int'(gx_o), q_gx.pop_front());
                chk("stream_gy", int'(gy_o), q_gy.pop_front());
            end
        end
    endtask

    vec_t        tbl[9];
    vec_t        t0[4];
    vec_t        bp[4];
    logic        acc;
    logic        o;
    logic [71:0] cur;
    int          egx;
    int          egy;

    initial begin
        tbl[0] = '{mkw(0, 10, 20, 0, 10, 20, 0, 10, 20), 20, 0};
        tbl[1] = '{mkw(255, 128, 0, 255, 128, 0, 255, 128, 0), 255, 0};
        tbl[2] = '{mkw(255, 255, 255, 128, 128, 128, 0, 0, 0), 0, 255};
        tbl[3] = '{mkw(4, 0, 0, 0, 8, 0, 0, 0, 12), 2, 2};
        tbl[4] = '{mkw(0, 0, 0, 0, 0, 100, 0, 0, 0), 50, 0};
        tbl[5] = '{mkw(0, 0, 0, 0, 0, 0, 0, 3, 0), 0, 1};
        tbl[6] = '{mkw(0, 255, 0, 0, 0, 0, 0, 0, 0), 0, 127};
        tbl[7] = '{mkw(0, 0, 0, 3, 0, 0, 0, 0, 0), 1, 0};
        tbl[8] = '{mkw(0, 0, 200, 0, 0, 0, 50, 0, 0), 37, 37};

        t0[0] = '{mkw(0, 0, 200, 0, 0, 200, 0, 0, 200), 255, 0};
        t0[1] = '{mkw(4, 0, 0, 0, 8, 0, 0, 0, 12), 8, 8};
        t0[2] = '{mkw(0, 0, 0, 0, 0, 50, 0, 0, 0), 100, 0};
        t0[3] = '{mkw(0, 0, 200, 0, 0, 0, 50, 0, 0), 150, 150};

        bp[0] = '{mkw(0, 0, 40, 0, 0, 40, 0, 0, 40), 40, 0};
        bp[1] = '{mkw(9, 0, 0, 9, 0, 0, 9, 0, 0), 9, 0};
        bp[2] = '{mkw(0, 0, 0, 0, 0, 0, 60, 60, 60), 0, 60};
        bp[3] = '{mkw(100, 0, 0, 0, 0, 0, 0, 0, 0), 25, 25};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn_i = 1'b1;
        #1;
        chk("reset_valid_o", int'(valid_o), 0);
        chk("reset_gx_o", int'(gx_o), 0);
        chk("reset_gy_o", int'(gy_o), 0);
        chk("reset_ready_o", int'(ready_o), 1);

        // Latency of one beat with ready_i high
        tick(1'b1, tbl[0].win, tbl[0].gx, tbl[0].gy, 1'b1, acc, o);
        chk("lat_accept", int'(acc), 1);
        tick(1'b0, '0, 0, 0, 1'b1, acc, o);
        chk("lat_cycle1_valid", int'(o), 0);
        tick(1'b0, '0, 0, 0, 1'b1, acc, o);
        chk("lat_cycle2_valid", int'(o), 1);

        // Table vectors back to back
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, tbl[i].win, tbl[i].gx, tbl[i].gy, 1'b1, acc, o);
            chk("tbl_accept", int'(acc), 1);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 0, 0, 1'b1, acc, o);
        chk("tbl_drained", q_gx.size(), 0);

        // Backpressure: ready_i low, then high
        begin
            int acc_n;
            int h_gx;
            int h_gy;
            int p0;
            logic have_h;
            acc_n  = 0;
            have_h = 1'b0;
            h_gx   = 0;
            h_gy   = 0;
            for (int c = 0; c < 6; c++) begin
                tick(1'b1, bp[acc_n].win, bp[acc_n].gx, bp[acc_n].gy, 1'b0, acc, o);
                if (acc) acc_n++;
                if (o) begin
                    if (!have_h) begin
                        have_h = 1'b1;
                        h_gx   = int'(gx_o);
                        h_gy   = int'(gy_o);
                    end else begin
                        chk("bp_hold_valid", int'(valid_o), 1);
                        chk("bp_hold_gx", int'(gx_o), h_gx);
                        chk("bp_hold_gy", int'(gy_o), h_gy);
                    end
                end
            end
            chk("bp_accepts_stalled", acc_n, 2);
            chk("bp_ready_low", int'(ready_o), 0);
            chk("bp_first_gx", h_gx, 40);
            p0 = n_pop;
            for (int c = 0; c < 4; c++) begin
                if (acc_n < 4) begin
                    tick(1'b1, bp[acc_n].win, bp[acc_n].gx, bp[acc_n].gy, 1'b1, acc, o);
                    if (acc) acc_n++;
                end else begin
                    tick(1'b0, '0, 0, 0, 1'b1, acc, o);
                end
            end
            chk("bp_accepts_total", acc_n, 4);
            chk("bp_pops", n_pop - p0, 4);
            chk("bp_drained", q_gx.size(), 0);
        end

        // Random stream with random valid/ready
        begin
            int   sent;
            logic have;
            logic vin;
            sent = 0;
            have = 1'b0;
            cur  = '0;
            egx  = 0;
            egy  = 0;
            for (int c = 0; c < 3000 && (sent < 64 || q_gx.size() > 0); c++) begin
                if (!have && sent < 64) begin
                    cur  = 72'({$urandom(), $urandom(), $urandom()});
                    have = 1'b1;
                    model(cur, 2, egx, egy);
                end
                vin = have && ($urandom_range(0, 9) < 7);
                tick(vin, cur, egx, egy, $urandom_range(0, 9) < 6, acc, o);
                if (acc) begin
                    have = 1'b0;
                    sent++;
                end
            end
            chk("rand_sent", sent, 64);
            chk("rand_drained", q_gx.size(), 0);
        end

        // Reset with both stages full
        tick(1'b1, bp[0].win, bp[0].gx, bp[0].gy, 1'b0, acc, o);
        tick(1'b1, bp[1].win, bp[1].gx, bp[1].gy, 1'b0, acc, o);
        @(negedge clk);
        valid_i = 1'b0;
        #2;
        chk("rst_pre_full_valid", int'(valid_o), 1);
        chk("rst_pre_full_ready", int'(ready_o), 0);
        rstn_i = 1'b0;
        #1;
        chk("rst_async_valid", int'(valid_o), 0);
        chk("rst_async_gx", int'(gx_o), 0);
        chk("rst_async_gy", int'(gy_o), 0);
        q_gx.delete();
        q_gy.delete();
        @(negedge clk);
        #2;
        rstn_i = 1'b1;
        #1;
        chk("rst_release_ready", int'(ready_o), 1);
        begin
            int stale;
            stale = 0;
            for (int c = 0; c < 5; c++) begin
                tick(1'b0, '0, 0, 0, 1'b1, acc, o);
                if (o) stale++;
            end
            chk("rst_no_stale", stale, 0);
        end

        // SHIFT_P=0 instance: saturation and exact passthrough
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v0_i = 1'b1;
            win0 = t0[i].win;
            @(negedge clk);
            v0_i = 1'b0;
            @(negedge clk);
            #1;
            chk("sh0_valid", int'(v0_o), 1);
            chk("sh0_gx", int'(gx0), t0[i].gx);
            chk("sh0_gy", int'(gy0), t0[i].gy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
